// File: rtl/spi_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_seq_pkg
// Purpose  : Shared types for the SPI command sequencer: FSM state encoding,
//            table entry layout and a busy-state helper.
// Revision : 1.0 - initial release
// ============================================================================
package spi_seq_pkg;

  // Default entry geometry; the packed entry type below is built from these.
  localparam int SPI_DATA_W = 16;
  localparam int SPI_NUM_SS = 10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_STARTUP  = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_RDY = 3'd3,
    ST_GAP      = 3'd4,
    ST_DONE     = 3'd5
  } seq_state_t;

  typedef struct packed {
    logic [SPI_DATA_W-1:0] data;
    logic [SPI_NUM_SS-1:0] ss;
    logic                  cpol;
    logic                  cpha;
  } spi_entry_t;

  // A run is "in progress" in every state except the two resting states.
  function automatic logic is_busy_state(input seq_state_t s);
    return (s == ST_STARTUP) || (s == ST_ISSUE) ||
           (s == ST_WAIT_RDY) || (s == ST_GAP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_cmd_table.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_table
// Purpose  : DEPTH-entry command table. Synchronous write, asynchronous read,
//            no reset on the storage so it maps onto distributed RAM.
// Revision : 1.0 - initial release
// ============================================================================
module spi_cmd_table
  import spi_seq_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter int NUM_SS = SPI_NUM_SS,
  parameter int DEPTH  = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [NUM_SS-1:0] wr_ss,
  input  logic              wr_cpol,
  input  logic              wr_cpha,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [NUM_SS-1:0] rd_ss,
  output logic              rd_cpol,
  output logic              rd_cpha
);

  localparam int c_ENTRY_W = DATA_W + NUM_SS + 2;

  logic [c_ENTRY_W-1:0] r_mem [DEPTH];
  logic [c_ENTRY_W-1:0] w_rd_word;

  // Write port: one entry per strobed cycle, contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      r_mem[wr_addr] <= {wr_data, wr_ss, wr_cpol, wr_cpha};
    end
  end

  assign w_rd_word = r_mem[rd_addr];
  assign {rd_data, rd_ss, rd_cpol, rd_cpha} = w_rd_word;

endmodule
`default_nettype wire

// File: rtl/spi_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : spi_sequencer
// Purpose  : Plays a writable table of SPI commands to a shared SPI master
//            via trigger/ready, after a start-up delay or on request, with a
//            programmable idle gap between commands.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sequencer
  import spi_seq_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int NUM_SS         = 10,
  parameter int DEPTH          = 64,
  parameter int STARTUP_CYCLES = 1000,
  parameter int GAP_CYCLES     = 10,
  parameter int AUTO_START     = 1,
  localparam int AW            = $clog2(DEPTH),
  localparam int CW            = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CW-1:0]     num_cmds,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [NUM_SS-1:0] wr_ss,
  input  logic              wr_cpol,
  input  logic              wr_cpha,
  output logic [DATA_W-1:0] command,
  output logic [NUM_SS-1:0] ss,
  output logic              cpol,
  output logic              cpha,
  output logic              trigger,
  input  logic              ready,
  output logic              busy,
  output logic              done
);

  localparam seq_state_t    c_RESET_STATE = (AUTO_START != 0) ? ST_STARTUP : ST_IDLE;
  localparam logic [31:0]   c_STARTUP     = 32'(STARTUP_CYCLES);
  localparam logic [31:0]   c_GAP         = 32'(GAP_CYCLES);
  localparam logic [CW-1:0] c_DEPTH       = CW'(DEPTH);

  seq_state_t        r_state, w_state_nxt;
  logic [31:0]       r_delay, r_gap;
  logic [CW-1:0]     r_count, w_count_clamped;
  logic [AW-1:0]     r_index, w_index_nxt;
  logic              w_wr_ok, w_start_ok, w_last, w_launch, w_fwd;

  logic [DATA_W-1:0] w_tbl_data, w_command_nxt;
  logic [NUM_SS-1:0] w_tbl_ss, w_ss_nxt;
  logic              w_tbl_cpol, w_tbl_cpha, w_cpol_nxt, w_cpha_nxt;
  logic              w_trigger_nxt, w_busy_nxt, w_done_nxt;

  assign w_wr_ok         = wr_en && !busy;
  assign w_start_ok      = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_count_clamped = (num_cmds > c_DEPTH) ? c_DEPTH : num_cmds;
  assign w_last          = (CW'(r_index) == (r_count - CW'(1)));
  assign w_launch        = w_start_ok || ((r_state == ST_STARTUP) && (r_delay == '0));

  spi_cmd_table #(
    .DATA_W (DATA_W),
    .NUM_SS (NUM_SS),
    .DEPTH  (DEPTH)
  ) u_table (
    .clock   (clock),
    .wr_en   (w_wr_ok),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_ss   (wr_ss),
    .wr_cpol (wr_cpol),
    .wr_cpha (wr_cpha),
    .rd_addr (w_index_nxt),
    .rd_data (w_tbl_data),
    .rd_ss   (w_tbl_ss),
    .rd_cpol (w_tbl_cpol),
    .rd_cpha (w_tbl_cpha)
  );

  // A write accepted on the launching edge must be seen by the entry being
  // loaded on that same edge, so bypass the table for a matching address.
  assign w_fwd = w_wr_ok && (wr_addr == w_index_nxt);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_RESET_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-index decode.
  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_index_nxt = '0;
          w_state_nxt = (w_count_clamped == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_STARTUP: begin
        w_index_nxt = '0;
        if (r_delay == '0) begin
          w_state_nxt = (w_count_clamped == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (ready) begin
          if (w_last) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_index_nxt = r_index + 1'b1;
            w_state_nxt = (GAP_CYCLES == 0) ? ST_ISSUE : ST_GAP;
          end
        end
      end
      ST_GAP: begin
        // Leave on the edge where the gap counter reaches zero.
        if (r_gap <= 32'd1) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      default: begin
        w_state_nxt = c_RESET_STATE;
      end
    endcase
  end

  // Start-up delay, gap counter, entry index and latched command count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_delay <= c_STARTUP;
      r_gap   <= '0;
      r_index <= '0;
      r_count <= '0;
    end else begin
      r_index <= w_index_nxt;
      if (w_launch) begin
        r_count <= w_count_clamped;
      end
      if ((r_state == ST_STARTUP) && (r_delay != '0)) begin
        r_delay <= r_delay - 32'd1;
      end
      if ((r_state == ST_WAIT_RDY) && ready && !w_last) begin
        r_gap <= c_GAP;
      end else if ((r_state == ST_GAP) && (r_gap != '0)) begin
        r_gap <= r_gap - 32'd1;
      end
    end
  end

  // Next values of the registered outputs, keyed on the state being entered.
  always_comb begin
    w_trigger_nxt = (w_state_nxt == ST_ISSUE);
    w_busy_nxt    = is_busy_state(w_state_nxt);
    w_command_nxt = command;
    w_ss_nxt      = ss;
    w_cpol_nxt    = cpol;
    w_cpha_nxt    = cpha;
    case (w_state_nxt)
      ST_ISSUE: begin
        w_command_nxt = w_fwd ? wr_data : w_tbl_data;
        w_ss_nxt      = w_fwd ? wr_ss   : w_tbl_ss;
        w_cpol_nxt    = w_fwd ? wr_cpol : w_tbl_cpol;
        w_cpha_nxt    = w_fwd ? wr_cpha : w_tbl_cpha;
      end
      ST_WAIT_RDY: begin
        // hold the entry stable for the SPI master
      end
      ST_GAP: begin
        w_ss_nxt = '0;
      end
      default: begin
        w_command_nxt = '0;
        w_ss_nxt      = '0;
        w_cpol_nxt    = 1'b0;
        w_cpha_nxt    = 1'b0;
      end
    endcase

    w_done_nxt = done;
    if ((w_state_nxt == ST_DONE) && ((r_state != ST_DONE) || w_start_ok)) begin
      w_done_nxt = 1'b1;
    end else if (w_start_ok || ((r_state == ST_DONE) && w_wr_ok)) begin
      w_done_nxt = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      command <= '0;
      ss      <= '0;
      cpol    <= 1'b0;
      cpha    <= 1'b0;
      trigger <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      command <= w_command_nxt;
      ss      <= w_ss_nxt;
      cpol    <= w_cpol_nxt;
      cpha    <= w_cpha_nxt;
      trigger <= w_trigger_nxt;
      busy    <= w_busy_nxt;
      done    <= w_done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_sequencer
// Purpose  : Self-checking bench for spi_sequencer. Acts as the SPI master,
//            keeps a mirror of the command table and checks every played
//            entry, trigger timing, gaps and status flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_sequencer;
  import spi_seq_pkg::*;

  localparam int DW = 16, NS = 10, DEPTH = 64, S = 20, G = 3;
  localparam int AW = 6, CW = 7;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n, start, wr_en, wr_cpol, wr_cpha, ready;
  logic [CW-1:0] num_cmds;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data, command;
  logic [NS-1:0] wr_ss, ss;
  logic          cpol, cpha, trigger, busy, done;

  logic          b_start, b_wr_en, b_wr_cpol, b_wr_cpha, b_ready;
  logic [CW-1:0] b_num_cmds;
  logic [AW-1:0] b_wr_addr;
  logic [DW-1:0] b_wr_data, b_command;
  logic [NS-1:0] b_wr_ss, b_ss;
  logic          b_cpol, b_cpha, b_trigger, b_busy, b_done;

  spi_sequencer #(.DATA_W(DW), .NUM_SS(NS), .DEPTH(DEPTH), .STARTUP_CYCLES(S),
                  .GAP_CYCLES(G), .AUTO_START(1)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .num_cmds(num_cmds),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ss(wr_ss),
    .wr_cpol(wr_cpol), .wr_cpha(wr_cpha), .command(command), .ss(ss),
    .cpol(cpol), .cpha(cpha), .trigger(trigger), .ready(ready),
    .busy(busy), .done(done));

  spi_sequencer #(.DATA_W(DW), .NUM_SS(NS), .DEPTH(DEPTH), .STARTUP_CYCLES(S),
                  .GAP_CYCLES(0), .AUTO_START(0)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(b_start), .num_cmds(b_num_cmds),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_ss(b_wr_ss),
    .wr_cpol(b_wr_cpol), .wr_cpha(b_wr_cpha), .command(b_command), .ss(b_ss),
    .cpol(b_cpol), .cpha(b_cpha), .trigger(b_trigger), .ready(b_ready),
    .busy(b_busy), .done(b_done));

  typedef struct {
    int num;
    int exp_n;
    bit noise;
  } vec_t;

  spi_entry_t mem_m [DEPTH];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [27:0] cur();
    return {command, ss, cpol, cpha};
  endfunction

  function automatic spi_entry_t rnd_entry();
    spi_entry_t e;
    e.data = 16'($urandom);
    e.ss   = 10'($urandom);
    e.cpol = 1'($urandom);
    e.cpha = 1'($urandom);
    return e;
  endfunction

  task automatic wr(input int a, input spi_entry_t e);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    {wr_data, wr_ss, wr_cpol, wr_cpha} = e;
  endtask

  task automatic wait_trig(output int w, input int budget);
    w = 0;
    while (trigger !== 1'b1 && w < budget) begin
      tick();
      w++;
    end
    if (trigger !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL trig_timeout: got no trigger within %0d cycles expected trigger", budget);
    end
  endtask

  task automatic quiet(input int cycles);
    bit seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (trigger === 1'b1) seen = 1'b1;
    end
    check("no_extra_trigger", 32'(seen), 32'd0);
  endtask

  // Plays n entries as the SPI master; entry i must equal mirror[i].
  task automatic play(input int n, input int first_wait, input bit noise);
    int w, w0, lat;
    bit early;
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        wait_trig(w, first_wait + 10);
        check("first_trig_delay", 32'(w), 32'(first_wait));
      end
      check("entry_out", {4'd0, cur()}, {4'd0, mem_m[i]});
      check("busy_issue", 32'(busy), 32'd1);
      early = noise && ($urandom_range(0, 1) == 1);
      ready = early;
      tick();
      ready = 1'b0;
      lat = early ? $urandom_range(1, 4) : (noise ? $urandom_range(0, 4) : 0);
      for (int k = 0; k < lat; k++) begin
        check("hold_wait", {2'd0, trigger, busy, cur()}, {2'd0, 1'b0, 1'b1, mem_m[i]});
        if (noise) begin
          start = 1'($urandom);
          if ($urandom_range(0, 1) == 1) wr(int'($urandom_range(0, DEPTH-1)), rnd_entry());
        end
        tick();
        start = 1'b0;
        wr_en = 1'b0;
      end
      ready = 1'b1;
      tick();
      ready = 1'b0;
      if (i == n - 1) begin
        check("done_end", {1'b0, done, busy, trigger, cur()}, {1'b0, 1'b1, 1'b0, 1'b0, 28'd0});
      end else begin
        check("gap_ss", {19'd0, busy, trigger, done, ss}, {19'd0, 1'b1, 1'b0, 1'b0, 10'd0});
        w0 = 0;
        if (noise && $urandom_range(0, 1) == 1) begin
          ready = 1'b1;
          tick();
          ready = 1'b0;
          w0 = 1;
        end
        wait_trig(w, G + 10);
        check("gap_len", 32'(w0 + w), 32'(G));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       vt [7];
    spi_entry_t e;
    int         w, n, exp_n;

    vt[0] = '{3, 3, 1'b0};
    vt[1] = '{0, 0, 1'b0};
    vt[2] = '{1, 1, 1'b1};
    vt[3] = '{64, 64, 1'b0};
    vt[4] = '{70, 64, 1'b1};
    vt[5] = '{127, 64, 1'b1};
    vt[6] = '{2, 2, 1'b1};

    reset_n = 1'b0; start = 1'b0; ready = 1'b0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; wr_ss = '0; wr_cpol = 1'b0; wr_cpha = 1'b0; num_cmds = '0;
    b_start = 1'b0; b_ready = 1'b0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
    b_wr_ss = '0; b_wr_cpol = 1'b0; b_wr_cpha = 1'b0; b_num_cmds = '0;

    // Reset state and automatic start-up run with a zero count.
    tick();
    tick();
    check("reset_out", {1'b0, trigger, busy, done, cur()}, 32'd0);
    check("b_reset_out", {b_trigger, b_busy, b_done, b_command, b_ss, b_cpol, b_cpha}, 32'd0);
    reset_n = 1'b1;
    tick();
    check("startup_busy", {29'd0, busy, trigger, done}, {29'd0, 3'b100});
    for (int j = 0; j < 3; j++) begin
      wr(j, rnd_entry());
      tick();
    end
    wr_en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 6; k <= S; k++) tick();
    check("startup_hold", {29'd0, busy, trigger, done}, {29'd0, 3'b100});
    tick();
    check("auto_zero_done", {29'd0, busy, trigger, done}, {29'd0, 3'b001});

    // Fill the table while idle.
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = rnd_entry();
      wr(i, mem_m[i]);
      tick();
      if (i == 0) check("wr_clears_done", 32'(done), 32'd0);
    end
    wr_en = 1'b0;

    // Table-driven runs: requested count vs. count actually played.
    for (int v = 0; v < 7; v++) begin
      num_cmds = CW'(vt[v].num);
      start = 1'b1;
      tick();
      start = 1'b0;
      if (vt[v].exp_n == 0)
        check("zero_cmds", {29'd0, done, busy, trigger}, {29'd0, 3'b100});
      else
        play(vt[v].exp_n, 0, vt[v].noise);
      quiet(G + 4);
    end

    // Write landing in the same cycle as start.
    e = rnd_entry();
    mem_m[0] = e;
    wr(0, e);
    num_cmds = CW'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    play(2, 0, 1'b0);

    // Randomized runs against the mirror.
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < int'($urandom_range(1, 5)); j++) begin
        n = int'($urandom_range(0, DEPTH-1));
        mem_m[n] = rnd_entry();
        wr(n, mem_m[n]);
        tick();
        wr_en = 1'b0;
        check("rnd_wr_done_clr", 32'(done), 32'd0);
      end
      n = int'($urandom_range(0, 80));
      exp_n = (n > DEPTH) ? DEPTH : n;
      num_cmds = CW'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
      if (exp_n == 0)
        check("rnd_zero_cmds", {29'd0, done, busy, trigger}, {29'd0, 3'b100});
      else
        play(exp_n, 0, 1'b1);
      quiet(G + 4);
    end

    // Asynchronous reset while waiting for ready on entry 2.
    num_cmds = CW'(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_trig(w, 20);
      check("pre_reset_entry", {4'd0, cur()}, {4'd0, mem_m[i]});
      tick();
      if (i < 2) begin
        ready = 1'b1;
        tick();
        ready = 1'b0;
      end
    end
    #1 reset_n = 1'b0;
    #1;
    check("async_reset", {1'b0, trigger, busy, done, ss, command}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    for (int j = 0; j < 3; j++) begin
      wr(j, rnd_entry());
      tick();
    end
    wr_en = 1'b0;
    play(5, S + 1 - 4, 1'b1);

    // AUTO_START=0, GAP_CYCLES=0 instance.
    check("b_idle", {29'd0, b_busy, b_trigger, b_done}, 32'd0);
    b_wr_en = 1'b1; b_wr_addr = AW'(0); b_wr_data = 16'h2600; b_wr_ss = 10'b10;
    tick();
    b_wr_addr = AW'(1); b_wr_data = 16'hDC40; b_wr_cpol = 1'b1;
    tick();
    b_wr_en = 1'b0; b_wr_cpol = 1'b0;
    b_num_cmds = CW'(2);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check("b_issue0", {2'd0, b_trigger, b_busy, b_command, b_ss, b_cpol, b_cpha},
          {2'd0, 2'b11, 16'h2600, 10'h002, 2'b00});
    tick();
    check("b_wait0", {15'd0, b_trigger, b_command}, {15'd0, 1'b0, 16'h2600});
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    check("b_issue1", {2'd0, b_trigger, b_busy, b_command, b_ss, b_cpol, b_cpha},
          {2'd0, 2'b11, 16'hDC40, 10'h002, 2'b10});
    tick();
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    check("b_done", {3'd0, b_done, b_busy, b_trigger, b_ss, b_command},
          {3'd0, 1'b1, 1'b0, 1'b0, 10'd0, 16'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
